// File: rtl/rx_sched_pkg.sv
// rx_sched_pkg -- shared definitions for the receive-window scheduler.
//   rx_state_e    : scheduler FSM state encoding
//   OVR_W         : width of the dropped-result counter
//   WIN_LOG2_DEF  : default log2 of the integration window length
//   SETTLE_DEF    : default post-switch settle length in cycles
//   rr_pick()     : round-robin channel choice from mask and preference pointer
package rx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_INTEG   = 2'd2,
    ST_PUBLISH = 2'd3
  } rx_state_e;

  localparam int OVR_W        = 8;
  localparam int WIN_LOG2_DEF = 11;
  localparam int SETTLE_DEF   = 16;

  // ptr holds the preferred channel; fall back to the other one when the
  // preferred channel is masked off. Only meaningful when mask != 0.
  function automatic logic rr_pick(input logic [1:0] mask, input logic ptr);
    return mask[ptr] ? ptr : ~ptr;
  endfunction

endpackage

// File: rtl/rx_window_sched_if.sv
// rx_window_sched_if -- result handshake between the scheduler and its consumer.
//   res_data  : ones-count of the published window (WIN_LOG2+1 bits)
//   res_ch    : receiver index the count belongs to
//   res_valid : result available, held until accepted
//   res_ready : consumer accept; transfer when res_valid & res_ready
// Modports: master (scheduler side), slave (consumer side).
interface rx_window_sched_if
  import rx_sched_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF
);

  logic [WIN_LOG2:0] res_data;
  logic              res_ch;
  logic              res_valid;
  logic              res_ready;

  modport master (output res_data, output res_ch, output res_valid, input res_ready);
  modport slave  (input res_data, input res_ch, input res_valid, output res_ready);

endinterface

// File: rtl/rx_win_timer.sv
// rx_win_timer -- loadable down-counter shared by the settle and window phases.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : start a run of load_val+1 cycles (wins over clear)
//   clear     : stop the current run without a done pulse
//   load_val  : cycles-minus-one for the next run
//   done      : one-cycle pulse during the last cycle of a run
module rx_win_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic             active;

  assign done = active && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      active <= 1'b1;
    end else if (clear) begin
      active <= 1'b0;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/rx_window_sched.sv
// rx_window_sched -- time-multiplexes two receivers onto one ones-count
// accumulator: settle after each switch, integrate for 2^WIN_LOG2 cycles,
// publish the count through a valid/ready result port.
//   clk, rst    : clock, asynchronous active-high reset
//   enable      : run request; low returns to IDLE (aborting a running window)
//   ch_mask     : per-receiver enable, sampled only when picking a channel
//   sig         : comparator bits from receivers 0/1
//   rx_sel      : receiver routed to the accumulator
//   oe          : high while integrating
//   busy        : high outside IDLE
//   overrun_cnt : results dropped because the previous one was not accepted
//   res_if      : result handshake (master side)
// Optional feature: define RX_SCHED_OVERRUN_CNT_EN to build the saturating
// overrun counter; otherwise overrun_cnt is tied to zero.
module rx_window_sched
  import rx_sched_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int SETTLE   = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       ch_mask,
  input  logic [1:0]       sig,
  output logic             rx_sel,
  output logic             oe,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt,
  rx_window_sched_if.master res_if
);

  localparam int CNT_W = (WIN_LOG2 > 8) ? WIN_LOG2 : 8;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] WIN_LD    = CNT_W'((1 << WIN_LOG2) - 1);

  rx_state_e        state, state_n;
  logic             tmr_load, tmr_clear, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic             pick_go, pick, rr_ptr;
  logic [WIN_LOG2:0] acc;
  logic             pub_ok;

  assign pick      = rr_pick(ch_mask, rr_ptr);
  assign tmr_clear = (state_n == ST_IDLE);
  assign pub_ok    = (state == ST_PUBLISH) && (!res_if.res_valid || res_if.res_ready);

  rx_win_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .clear    (tmr_clear),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    pick_go  = 1'b0;
    case (state)
      ST_IDLE, ST_PUBLISH: begin
        // PUBLISH always re-enters SETTLE, even when the pick repeats the channel
        if (enable && (ch_mask != 2'b00)) begin
          state_n  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
          pick_go  = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else if (tmr_done) begin
          state_n  = ST_INTEG;
          tmr_load = 1'b1;
          tmr_val  = WIN_LD;
        end
      end
      ST_INTEG: begin
        if (!enable)       state_n = ST_IDLE;
        else if (tmr_done) state_n = ST_PUBLISH;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered status and channel routing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe     <= 1'b0;
      busy   <= 1'b0;
      rx_sel <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      oe   <= (state_n == ST_INTEG);
      busy <= (state_n != ST_IDLE);
      if (pick_go) begin
        rx_sel <= pick;
        rr_ptr <= ~pick;
      end
    end
  end

  // Accumulator: held at zero through SETTLE so INTEG always starts clean,
  // which also discards any sum left over from an aborted window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (state == ST_SETTLE) begin
      acc <= '0;
    end else if (state == ST_INTEG) begin
      acc <= acc + {{WIN_LOG2{1'b0}}, sig[rx_sel]};
    end
  end

  // Result port: a new result may only replace one that is being taken this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_if.res_data  <= '0;
      res_if.res_ch    <= 1'b0;
      res_if.res_valid <= 1'b0;
    end else if (pub_ok) begin
      res_if.res_data  <= acc;
      res_if.res_ch    <= rx_sel;
      res_if.res_valid <= 1'b1;
    end else if (res_if.res_valid && res_if.res_ready) begin
      res_if.res_valid <= 1'b0;
    end
  end

`ifdef RX_SCHED_OVERRUN_CNT_EN
  logic [OVR_W-1:0] ovr_q;
  logic             drop;

  assign drop = (state == ST_PUBLISH) && res_if.res_valid && !res_if.res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         ovr_q <= '0;
    else if (drop && (ovr_q != '1))  ovr_q <= ovr_q + 1'b1;
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: doc/rx_window_sched.md
RX_WINDOW_SCHED -- requirements
Module: rx_window_sched

Interface
REQ-001 Parameter WIN_LOG2, default 11, SHALL set the integration window to 2^WIN_LOG2 cycles (legal 4..11).
REQ-002 Parameter SETTLE, default 16, SHALL set the post-switch settle length in cycles (legal 1..255).
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 enable  in  1  run request; low forces IDLE.
REQ-006 ch_mask  in  2  per-receiver enable; bit n enables sig[n].
REQ-007 sig  in  2  comparator bits from receivers 0/1.
REQ-008 rx_sel  out  1  receiver currently routed to the shared accumulator.
REQ-009 oe  out  1  high only while integrating.
REQ-010 busy  out  1  high in any state except IDLE.
REQ-011 res_data  out  WIN_LOG2+1  ones-count of the last published window.
REQ-012 res_ch  out  1  receiver index of res_data.
REQ-013 res_valid  out  1  result available; held until accepted.
REQ-014 res_ready  in  1  consumer accept; transfer when res_valid & res_ready.
REQ-015 overrun_cnt  out  8  dropped-result count (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, INTEG, PUBLISH.
REQ-017 IDLE -> SETTLE when enable=1 and ch_mask!=0; rx_sel loads the selected channel on that edge.
REQ-018 Channel selection SHALL be round-robin: the other channel if its mask bit is set, else the same channel; the first pick after reset is the lowest set bit.
REQ-019 SETTLE SHALL last exactly SETTLE cycles, then go to INTEG with accumulator cleared.
REQ-020 INTEG SHALL last exactly 2^WIN_LOG2 cycles, adding sig[rx_sel] each cycle; full-scale 2^WIN_LOG2 SHALL be representable without wrap.
REQ-021 PUBLISH SHALL last one cycle: if res_valid=0, or res_valid=1 and res_ready=1 in that cycle, load res_data/res_ch and set res_valid; otherwise drop the result and raise overrun.
REQ-022 res_valid SHALL clear on the cycle after a transfer unless PUBLISH reloads it that cycle.
REQ-023 After PUBLISH: SETTLE on the next channel if enable=1 and ch_mask!=0, else IDLE; if the channel is unchanged, SETTLE SHALL still be entered.
REQ-024 ch_mask changes SHALL only take effect at the next selection; the running window completes.
REQ-025 enable=0 in SETTLE or INTEG SHALL abort to IDLE on the next edge, discard the partial sum, and leave res_valid/res_data untouched.
REQ-026 oe SHALL be registered and equal (state==INTEG); busy SHALL be registered.
REQ-027 res_data/res_ch SHALL not change while res_valid=1 and res_ready=0.

Reset
REQ-028 rst SHALL asynchronously force IDLE, rx_sel=0, oe=0, busy=0, res_data=0, res_ch=0, res_valid=0, overrun_cnt=0, all counters and round-robin pointer 0.

Configuration
REQ-029 With RX_SCHED_OVERRUN_CNT_EN defined, overrun_cnt SHALL increment by 1 per dropped result, saturate at 255, and clear only on rst.
REQ-030 Without RX_SCHED_OVERRUN_CNT_EN, overrun_cnt SHALL be constant 0, no counter logic inferred; drop behaviour unchanged.

Structure
REQ-031 Shared package rx_sched_pkg SHALL hold the state enum, the 8-bit overrun width constant and the default WIN_LOG2/SETTLE values.
REQ-032 One sub-module, rx_win_timer, SHALL provide the loadable down-counter used for both settle and window length, with a one-cycle done pulse.

Verification
REQ-033 mask=01, sig[0]=1 constant, ready=1, WIN_LOG2=4, SETTLE=2 -> res_data=16, res_ch=0 every 19 cycles; oe high exactly 16 cycles per window.
REQ-034 mask=11, sig=2'b01 constant -> results alternate ch0=16, ch1=0; rx_sel toggles once per window.
REQ-035 ready=0 for three windows -> first result held unchanged, overrun_cnt=2 (macro on) / 0 (macro off).
REQ-036 enable dropped at INTEG cycle 5 -> IDLE next edge, oe=0, no new res_valid, previous result intact.
REQ-037 rst pulsed mid-INTEG with res_valid=1 -> all outputs 0 asynchronously; restart selects ch0 first.
